// File: rtl/magma_irq_ctrl_if.sv
// -----------------------------------------------------------------------------
// magma_irq_ctrl_if
//   Bundle of the push-button / CPU interrupt signals of magma_irq_ctrl.
//   master : board + CPU side (drives buttons, enables and ack)
//   slave  : interrupt controller side
// Signals
//   btn_i      NUM_IRQ  raw asynchronous button levels
//   irq_en_i   NUM_IRQ  per-line enable mask (1 = may be requested)
//   irq_ack_i  1        CPU accepts the presented irq (1-cycle pulse)
//   irq_req_o  1        interrupt request to the CPU
//   irq_num_o  IDX_W    index of the presented irq, valid while irq_req_o=1
//   pending_o  NUM_IRQ  pending bits (status)
// -----------------------------------------------------------------------------
interface magma_irq_ctrl_if #(
   parameter int NUM_IRQ = 4,
   parameter int IDX_W   = 2
);
   logic [NUM_IRQ-1:0] btn_i;
   logic [NUM_IRQ-1:0] irq_en_i;
   logic               irq_ack_i;
   logic               irq_req_o;
   logic [IDX_W-1:0]   irq_num_o;
   logic [NUM_IRQ-1:0] pending_o;

   modport master (
      output btn_i, irq_en_i, irq_ack_i,
      input  irq_req_o, irq_num_o, pending_o
   );

   modport slave (
      input  btn_i, irq_en_i, irq_ack_i,
      output irq_req_o, irq_num_o, pending_o
   );
endinterface

// File: rtl/magma_irq_ctrl.sv
// -----------------------------------------------------------------------------
// magma_irq_ctrl
//   Interrupt controller between the board push-buttons and the magma CPU.
//   Each line is synchronised (2 FF), debounced, rising-edge detected and
//   latched into a pending bit. Pending & enabled lines are arbitrated and one
//   request plus its vector number is held towards the CPU until acknowledged,
//   followed by a guaranteed low cycle before the next request.
// Ports
//   clk_i    in  1        system clock
//   arstn_i  in  1        asynchronous active-low reset
//   bus      slave modport of magma_irq_ctrl_if (buttons, enables, ack,
//            request, vector number, pending status)
// Configuration
//   IRQ_ROUND_ROBIN_EN  defined   : round-robin selection starting after the
//                                   last acknowledged line
//                       undefined : fixed priority, lowest index wins
// -----------------------------------------------------------------------------
module magma_irq_ctrl #(
   parameter int NUM_IRQ      = 4,
   parameter int DEBOUNCE_CYC = 50000,
   parameter int CNT_W        = 16,
   parameter int IDX_W        = 2
) (
   input  logic             clk_i,
   input  logic             arstn_i,
   magma_irq_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_GAP} state_t;

   state_t             r_state;
   state_t             w_state_next;
   logic               r_req;
   logic               w_req_next;
   logic [IDX_W-1:0]   r_num;
   logic [IDX_W-1:0]   w_num_next;
   logic [NUM_IRQ-1:0] r_pending;
   logic [NUM_IRQ-1:0] w_rise;
   logic [NUM_IRQ-1:0] w_cand;
   logic [NUM_IRQ-1:0] w_ack_clr;
   logic [IDX_W-1:0]   w_win;
   logic               w_ack_req;

   // ------------------------------------------------------------------
   // Per-line synchroniser, debouncer and rising-edge detector
   // ------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < NUM_IRQ; gi++) begin : g_line
         logic             r_sync1;
         logic             r_sync2;
         logic             r_stable;
         logic             r_stable_d;
         logic             r_rise;
         logic [CNT_W-1:0] r_cnt;

         always_ff @(posedge clk_i or negedge arstn_i) begin
            if (!arstn_i) begin
               r_sync1    <= 1'b0;
               r_sync2    <= 1'b0;
               r_stable   <= 1'b0;
               r_stable_d <= 1'b0;
               r_rise     <= 1'b0;
               r_cnt      <= '0;
            end else begin
               r_sync1    <= bus.btn_i[gi];
               r_sync2    <= r_sync1;
               r_stable_d <= r_stable;
               // Registered edge pulse: one cycle, falling edges ignored
               r_rise     <= r_stable & ~r_stable_d;
               // Counter only runs while the synced level disagrees with
               // the accepted level; any agreement restarts the count.
               if (r_sync2 == r_stable) begin
                  r_cnt <= '0;
               end else if (r_cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
                  r_stable <= r_sync2;
                  r_cnt    <= '0;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
         end

         assign w_rise[gi] = r_rise;
      end
   endgenerate

   // ------------------------------------------------------------------
   // Pending bits: a new rise on the acked line wins over the clear
   // ------------------------------------------------------------------
   assign w_ack_req = (r_state == ST_REQ) && bus.irq_ack_i;
   assign w_ack_clr = w_ack_req ? (NUM_IRQ'(1) << r_num) : '0;
   assign w_cand    = r_pending & bus.irq_en_i;

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         r_pending <= '0;
      end else begin
         r_pending <= (r_pending & ~w_ack_clr) | w_rise;
      end
   end

   // ------------------------------------------------------------------
   // Winner selection
   // ------------------------------------------------------------------
`ifdef IRQ_ROUND_ROBIN_EN
   logic [IDX_W-1:0] r_last;

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         r_last <= '0;
      end else if (w_ack_req) begin
         r_last <= r_num;
      end
   end

   // First candidate found searching upward from last+1 (wrapping)
   always_comb begin
      int  k_idx;
      logic found;
      w_win = '0;
      found = 1'b0;
      for (int k = 1; k <= NUM_IRQ; k++) begin
         k_idx = (int'(r_last) + k) % NUM_IRQ;
         if (!found && w_cand[k_idx]) begin
            w_win = IDX_W'(k_idx);
            found = 1'b1;
         end
      end
   end
`else
   // Scan from the top so the lowest set index is the last assignment
   always_comb begin
      w_win = '0;
      for (int k = NUM_IRQ - 1; k >= 0; k--) begin
         if (w_cand[k]) begin
            w_win = IDX_W'(k);
         end
      end
   end
`endif

   // ------------------------------------------------------------------
   // Request FSM: state register / next state / outputs
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         r_state <= ST_IDLE;
         r_req   <= 1'b0;
         r_num   <= '0;
      end else begin
         r_state <= w_state_next;
         r_req   <= w_req_next;
         r_num   <= w_num_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (|w_cand)          w_state_next = ST_REQ;
         ST_REQ:  if (bus.irq_ack_i)    w_state_next = ST_GAP;
         ST_GAP:                        w_state_next = ST_IDLE;
         default:                       w_state_next = ST_IDLE;
      endcase
   end

   // Vector number is captured only on grant, so it stays frozen in REQ
   // even if the enable for that line is withdrawn.
   always_comb begin
      w_req_next = (w_state_next == ST_REQ);
      w_num_next = r_num;
      if (r_state == ST_IDLE && (|w_cand)) begin
         w_num_next = w_win;
      end
   end

   assign bus.irq_req_o = r_req;
   assign bus.irq_num_o = r_num;
   assign bus.pending_o = r_pending;

endmodule
